// File: rtl/usb_cmd_frame_parser.sv
// usb_cmd_frame_parser
// Delimits fixed 8-byte command frames (HDR0 HDR1 ADDR D3 D2 D1 D0 CSUM) from the USB FIFO byte
// stream. It checks the header and the additive checksum, and presents good frames to the command
// register block as a one-cycle cmdvalid pulse. Bad or stalled frames are dropped and counted.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-low reset
//   rx_data      byte from the FIFO reader
//   rx_valid     rx_data valid this cycle (always accepted)
//   cmdvalid     one-cycle pulse: good frame decoded
//   cmd_addr     address of the last good frame
//   cmd_data     data of the last good frame, {D3,D2,D1,D0}
//   csum_err     one-cycle pulse: checksum mismatch
//   timeout_err  one-cycle pulse: inter-byte timeout aborted a frame
//   err_cnt      saturating count of csum_err + timeout_err events
module usb_cmd_frame_parser #(
  parameter logic [7:0]  HDR0           = 8'h55,
  parameter logic [7:0]  HDR1           = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        cmdvalid,
  output logic [7:0]  cmd_addr,
  output logic [31:0] cmd_data,
  output logic        csum_err,
  output logic        timeout_err,
  output logic [7:0]  err_cnt
);

  localparam int unsigned     TmoW    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StHdr0,
    StHdr1,
    StAddr,
    StData,
    StCsum
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      addr_sh_q, addr_sh_d;
  logic [31:0]     data_sh_q, data_sh_d;
  logic [7:0]      sum_q, sum_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            tmo_hit;
  logic            cmdvalid_d, csum_err_d, timeout_err_d;
  logic [7:0]      cmd_addr_d;
  logic [31:0]     cmd_data_d;
  logic [7:0]      err_cnt_d;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    addr_sh_d     = addr_sh_q;
    data_sh_d     = data_sh_q;
    sum_d         = sum_q;
    cmd_addr_d    = cmd_addr;
    cmd_data_d    = cmd_data;
    cmdvalid_d    = 1'b0;
    csum_err_d    = 1'b0;
    timeout_err_d = 1'b0;

    // A byte arriving on the threshold cycle wins, so the timeout needs an idle cycle.
    tmo_hit = (state_q != StHdr0) && !rx_valid && (tmo_q == TmoLast);

    if (rx_valid || (state_q == StHdr0) || tmo_hit) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TmoW'(1);
    end

    if (tmo_hit) begin
      state_d       = StHdr0;
      timeout_err_d = 1'b1;
    end else if (rx_valid) begin
      case (state_q)
        StHdr0: begin
          if (rx_data == HDR0) state_d = StHdr1;
        end
        StHdr1: begin
          // A repeated HDR0 may be the real start of frame, so stay armed for HDR1.
          if (rx_data == HDR1) begin
            state_d = StAddr;
          end else if (rx_data != HDR0) begin
            state_d = StHdr0;
          end
        end
        StAddr: begin
          addr_sh_d = rx_data;
          sum_d     = rx_data;
          idx_d     = 2'd0;
          state_d   = StData;
        end
        StData: begin
          data_sh_d = {data_sh_q[23:0], rx_data};
          sum_d     = sum_q + rx_data;
          idx_d     = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = StCsum;
        end
        StCsum: begin
          if (rx_data == sum_q) begin
            cmd_addr_d = addr_sh_q;
            cmd_data_d = data_sh_q;
            cmdvalid_d = 1'b1;
          end else begin
            csum_err_d = 1'b1;
          end
          state_d = StHdr0;
        end
        default: state_d = StHdr0;
      endcase
    end

    err_cnt_d = err_cnt;
    if ((csum_err_d || timeout_err_d) && (err_cnt != 8'hFF)) begin
      err_cnt_d = err_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StHdr0;
      idx_q       <= 2'd0;
      addr_sh_q   <= 8'h00;
      data_sh_q   <= 32'h0;
      sum_q       <= 8'h00;
      tmo_q       <= '0;
      cmdvalid    <= 1'b0;
      csum_err    <= 1'b0;
      timeout_err <= 1'b0;
      cmd_addr    <= 8'h00;
      cmd_data    <= 32'h0;
      err_cnt     <= 8'h00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
      cmdvalid    <= cmdvalid_d;
      csum_err    <= csum_err_d;
      timeout_err <= timeout_err_d;
      cmd_addr    <= cmd_addr_d;
      cmd_data    <= cmd_data_d;
      err_cnt     <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_usb_cmd_frame_parser.sv
// Testbench for usb_cmd_frame_parser: directed frames plus randomized traffic, checked by a
// scoreboard. The frame-level reference model pushes the expected events, and a monitor pops and
// compares them.
module tb_usb_cmd_frame_parser;

  localparam int unsigned TmoCycles = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        cmdvalid;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        csum_err;
  logic        timeout_err;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  usb_cmd_frame_parser #(
    .HDR0          (8'h55),
    .HDR1          (8'hA5),
    .TIMEOUT_CYCLES(TmoCycles)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .cmdvalid   (cmdvalid),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .csum_err   (csum_err),
    .timeout_err(timeout_err),
    .err_cnt    (err_cnt)
  );

  localparam int EvGood = 0;
  localparam int EvCsum = 1;
  localparam int EvTmo  = 2;

  typedef struct {
    int          kind;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [7:0]  errs;
    int          due;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;

  // Reference model: the bytes of the frame collected so far, and idle cycles since the last byte.
  logic [7:0]  frame_q[$];
  int          idle_cnt = 0;
  logic [7:0]  m_addr = 8'h00;
  logic [31:0] m_data = 32'h0;
  logic [7:0]  m_errs = 8'h00;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push_ev(int kind);
    ev_t e;
    e.kind = kind;
    e.addr = m_addr;
    e.data = m_data;
    e.errs = m_errs;
    e.due  = cyc + 1;
    exp_q.push_back(e);
  endfunction

  function automatic void model_error(int kind);
    if (m_errs != 8'hFF) m_errs = m_errs + 8'd1;
    push_ev(kind);
  endfunction

  function automatic void model_byte(logic [7:0] b);
    logic [7:0] s;
    idle_cnt = 0;
    if (frame_q.size() == 0) begin
      if (b == 8'h55) frame_q.push_back(b);
    end else if (frame_q.size() == 1) begin
      if (b == 8'hA5) frame_q.push_back(b);
      else if (b != 8'h55) frame_q.delete();
    end else begin
      frame_q.push_back(b);
      if (frame_q.size() == 8) begin
        s = frame_q[2] + frame_q[3] + frame_q[4] + frame_q[5] + frame_q[6];
        if (s == frame_q[7]) begin
          m_addr = frame_q[2];
          m_data = {frame_q[3], frame_q[4], frame_q[5], frame_q[6]};
          push_ev(EvGood);
        end else begin
          model_error(EvCsum);
        end
        frame_q.delete();
      end
    end
  endfunction

  function automatic void model_idle();
    if (frame_q.size() > 0) begin
      idle_cnt++;
      if (idle_cnt == TmoCycles) begin
        frame_q.delete();
        idle_cnt = 0;
        model_error(EvTmo);
      end
    end
  endfunction

  // Monitor
  logic rst_seen = 1'b0;
  ev_t  cur;
  logic [7:0]  h_addr = 8'h00;
  logic [31:0] h_data = 32'h0;
  logic [7:0]  h_errs = 8'h00;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      check("missing_pulse", 32'(exp_q[0].kind), 32'hFFFF_FFFF);
      void'(exp_q.pop_front());
    end
    if (!rst_seen) begin
      check("reset_pulses", {29'd0, cmdvalid, csum_err, timeout_err}, 32'd0);
      check("reset_addr", 32'(cmd_addr), 32'd0);
      check("reset_data", cmd_data, 32'd0);
      check("reset_errcnt", 32'(err_cnt), 32'd0);
      h_addr = 8'h00;
      h_data = 32'h0;
      h_errs = 8'h00;
    end else if (cmdvalid || csum_err || timeout_err) begin
      check("pulse_onehot", 32'(cmdvalid) + 32'(csum_err) + 32'(timeout_err), 32'd1);
      if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
        check("unexpected_pulse", {29'd0, cmdvalid, csum_err, timeout_err}, 32'd0);
      end else begin
        cur = exp_q.pop_front();
        check("event_kind", cmdvalid ? 32'(EvGood) : (csum_err ? 32'(EvCsum) : 32'(EvTmo)),
              32'(cur.kind));
        check("event_addr", 32'(cmd_addr), 32'(cur.addr));
        check("event_data", cmd_data, cur.data);
        check("event_errcnt", 32'(err_cnt), 32'(cur.errs));
        h_addr = cur.addr;
        h_data = cur.data;
        h_errs = cur.errs;
      end
    end else begin
      check("hold_addr", 32'(cmd_addr), 32'(h_addr));
      check("hold_data", cmd_data, h_data);
      check("hold_errcnt", 32'(err_cnt), 32'(h_errs));
    end
  end

  // Stimulus
  task automatic drive(input logic v, input logic [7:0] b);
    rx_valid = v;
    rx_data  = v ? b : 8'($urandom);
    if (v) model_byte(b);
    else   model_idle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
  endtask

  task automatic send_seq(input logic [63:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) drive(1'b1, w[i*8 +: 8]);
  endtask

  task automatic apply_reset();
    reset    = 1'b0;
    rx_valid = 1'b0;
    frame_q.delete();
    idle_cnt = 0;
    m_addr   = 8'h00;
    m_data   = 32'h0;
    m_errs   = 8'h00;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic logic [63:0] make_frame(logic [7:0] a, logic [31:0] d, logic bad);
    logic [7:0] s;
    s = a + d[31:24] + d[23:16] + d[15:8] + d[7:0];
    if (bad) s = s + 8'($urandom_range(1, 255));
    return {8'h55, 8'hA5, a, d, s};
  endfunction

  initial begin
    logic [63:0] f;
    int          k;
    int          r;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);

    // Good frame, back to back.
    send_seq(64'h55A5_0200_0040_0042, 8);
    idle(2);
    check("t1_addr", 32'(cmd_addr), 32'h02);
    check("t1_data", cmd_data, 32'h0000_4000);
    check("t1_errcnt", 32'(err_cnt), 32'd0);

    // Bad checksum, then a good frame immediately after.
    send_seq(64'h55A5_0200_0040_0043, 8);
    send_seq(64'h55A5_0400_0100_0106, 8);
    idle(2);
    check("t2_addr", 32'(cmd_addr), 32'h04);
    check("t2_data", cmd_data, 32'h0001_0001);
    check("t2_errcnt", 32'(err_cnt), 32'd1);

    // Resync on junk and a repeated header byte.
    send_seq(64'h12, 1);
    send_seq(64'h5555_A501_0000_0002, 8);
    send_seq(64'h03, 1);
    idle(2);
    check("t3_addr", 32'(cmd_addr), 32'h01);
    check("t3_data", cmd_data, 32'h0000_0002);

    // Stall mid-frame, leftover bytes, then a good frame.
    send_seq(64'h55A5_0300, 4);
    idle(TmoCycles);
    send_seq(64'h0001_0203, 4);
    send_seq(64'h55A5_0711_2233_44B1, 8);
    idle(2);
    check("t4_addr", 32'(cmd_addr), 32'h07);
    check("t4_data", cmd_data, 32'h1122_3344);
    check("t4_errcnt", 32'(err_cnt), 32'd2);

    // Reset mid-frame, then a good frame.
    send_seq(64'h55A5_0100, 4);
    apply_reset();
    idle(1);
    check("t5_addr_cleared", 32'(cmd_addr), 32'h00);
    send_seq(64'h55A5_09DE_ADBE_EF41, 8);
    idle(2);
    check("t5_addr", 32'(cmd_addr), 32'h09);
    check("t5_data", cmd_data, 32'hDEAD_BEEF);

    // Error counter saturation.
    for (int i = 0; i < 260; i++) send_seq(64'h55A5_0000_0000_0001, 8);
    idle(2);
    check("t6_errcnt_sat", 32'(err_cnt), 32'hFF);
    check("t6_addr_kept", 32'(cmd_addr), 32'h09);
    apply_reset();
    idle(2);

    // Randomized traffic.
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 19);
      if (r < 8) begin
        f = make_frame(8'($urandom), $urandom, 1'b0);
        for (int i = 7; i >= 0; i--) begin
          drive(1'b1, f[i*8 +: 8]);
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
      end else if (r < 11) begin
        f = make_frame(8'($urandom), $urandom, 1'b1);
        send_seq(f, 8);
      end else if (r < 14) begin
        for (int i = 0; i < $urandom_range(1, 3); i++) begin
          drive(1'b1, ($urandom_range(0, 1) == 0) ? 8'h55 : 8'($urandom));
        end
      end else if (r < 17) begin
        // Stall partway through a frame, just below, at, or beyond the timeout.
        f = make_frame(8'($urandom), $urandom, 1'b0);
        k = $urandom_range(1, 7);
        for (int i = 7; i >= 8 - k; i--) drive(1'b1, f[i*8 +: 8]);
        idle(TmoCycles - 1 + $urandom_range(0, 2));
        for (int i = 7 - k; i >= 0; i--) drive(1'b1, f[i*8 +: 8]);
      end else if (r < 19) begin
        idle($urandom_range(0, 5));
      end else begin
        apply_reset();
      end
    end

    idle(TmoCycles + 5);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
